// File: rtl/lc4_alu_pkg.sv
// Shared LC4 execute-unit definitions: opcode and sub-op field values,
// FSM state encoding, and immediate extension helpers.
package lc4_alu_pkg;

  localparam logic [3:0] OP_BR      = 4'h0;
  localparam logic [3:0] OP_ARITH   = 4'h1;
  localparam logic [3:0] OP_CMP     = 4'h2;
  localparam logic [3:0] OP_JSR     = 4'h4;
  localparam logic [3:0] OP_LOGIC   = 4'h5;
  localparam logic [3:0] OP_LDR     = 4'h6;
  localparam logic [3:0] OP_STR     = 4'h7;
  localparam logic [3:0] OP_RTI     = 4'h8;
  localparam logic [3:0] OP_CONST   = 4'h9;
  localparam logic [3:0] OP_SHIFT   = 4'hA;
  localparam logic [3:0] OP_JMP     = 4'hC;
  localparam logic [3:0] OP_HICONST = 4'hD;
  localparam logic [3:0] OP_TRAP    = 4'hF;

  // insn[5:3] of OP_ARITH; insn[5] set selects ADDI
  localparam logic [2:0] AR_ADD = 3'b000;
  localparam logic [2:0] AR_MUL = 3'b001;
  localparam logic [2:0] AR_SUB = 3'b010;
  localparam logic [2:0] AR_DIV = 3'b011;

  // insn[8:7] of OP_CMP
  localparam logic [1:0] CMP_S  = 2'b00;
  localparam logic [1:0] CMP_U  = 2'b01;
  localparam logic [1:0] CMP_SI = 2'b10;
  localparam logic [1:0] CMP_UI = 2'b11;

  // insn[5:3] of OP_LOGIC; insn[5] set selects ANDI
  localparam logic [2:0] LG_AND = 3'b000;
  localparam logic [2:0] LG_NOT = 3'b001;
  localparam logic [2:0] LG_OR  = 3'b010;
  localparam logic [2:0] LG_XOR = 3'b011;

  // insn[5:4] of OP_SHIFT
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_MOD = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DIV  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Sign-extend the low `bits` bits of v to 64 bits; callers truncate to WIDTH.
  function automatic logic [63:0] sext64(input logic [15:0] v, input int unsigned bits);
    logic signed [63:0] t;
    t = $signed({v, 48'd0}) <<< (16 - bits);
    return t >>> (64 - bits);
  endfunction

  function automatic logic [63:0] zext64(input logic [15:0] v, input int unsigned bits);
    return {48'd0, v} & ((64'd1 << bits) - 64'd1);
  endfunction

endpackage

// File: rtl/lc4_div_iter.sv
// Iterative unsigned restoring divider retiring DIV_BITS quotient bits per cycle.
// A zero divisor yields quotient 0 and remainder 0.
module lc4_div_iter #(
  parameter int WIDTH    = 16,
  parameter int DIV_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int STEPS = WIDTH / DIV_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_p0, quo_p0, dsr_p0;
  logic             dz_p0;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH:0]   trial;

  always_comb begin
    rem_nx = rem_p0;
    quo_nx = quo_p0;
    trial  = '0;
    for (int k = 0; k < DIV_BITS; k++) begin
      trial  = {rem_nx, quo_nx[WIDTH-1]};
      quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dsr_p0}) begin
        rem_nx    = trial[WIDTH-1:0] - dsr_p0;
        quo_nx[0] = 1'b1;
      end else begin
        rem_nx = trial[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= CNT_W'(STEPS);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CNT_W'(1);
    end
  end

  // Dividend shifts out of quo_p0 as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (start) begin
      rem_p0 <= '0;
      quo_p0 <= dividend;
      dsr_p0 <= divisor;
      dz_p0  <= (divisor == '0);
    end else if (busy && cnt != '0) begin
      rem_p0 <= rem_nx;
      quo_p0 <= quo_nx;
    end
  end

  assign done      = busy && (cnt == '0);
  assign quotient  = dz_p0 ? '0 : quo_p0;
  assign remainder = dz_p0 ? '0 : rem_p0;

endmodule

// File: rtl/lc4_alu_seq.sv
// Multi-cycle LC4 execute unit: single-cycle ALU ops, iterative DIV/MOD.
// Define LC4_ALU_DIV_ZERO_FAST_EN to complete DIV/MOD by zero in one cycle.
module lc4_alu_seq #(
  parameter int WIDTH    = 16,
  parameter int DIV_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_insn,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_r1data,
  input  logic [WIDTH-1:0] i_r2data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);
  import lc4_alu_pkg::*;

  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                  state;
  logic                    mod_sel_p0;
  logic [3:0]              opcode;
  logic [3:0]              shamt;
  logic signed [WIDTH-1:0] r1_s;
  logic [WIDTH-1:0]        pc_inc, alu_res;
  logic [WIDTH-1:0]        imm5_s, imm6_s, imm7_s, imm7_u, imm9_s, imm11_s;
  logic                    is_div, is_mod, is_divmod, fast_zero;
  logic                    accept, div_start;
  logic                    div_busy, div_done;
  logic [WIDTH-1:0]        div_quo, div_rem;

  function automatic logic [WIDTH-1:0] cmp3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic sgn);
    logic gt;
    gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
    if (a == b)  return '0;
    else if (gt) return WIDTH'(1);
    else         return '1;
  endfunction

  assign opcode  = i_insn[15:12];
  assign shamt   = i_insn[3:0];
  assign r1_s    = i_r1data;
  assign pc_inc  = i_pc + WIDTH'(1);
  assign imm5_s  = WIDTH'(sext64(i_insn, 5));
  assign imm6_s  = WIDTH'(sext64(i_insn, 6));
  assign imm7_s  = WIDTH'(sext64(i_insn, 7));
  assign imm7_u  = WIDTH'(zext64(i_insn, 7));
  assign imm9_s  = WIDTH'(sext64(i_insn, 9));
  assign imm11_s = WIDTH'(sext64(i_insn, 11));

  assign is_div    = (opcode == OP_ARITH) && (i_insn[5:3] == AR_DIV);
  assign is_mod    = (opcode == OP_SHIFT) && (i_insn[5:4] == SH_MOD);
  assign is_divmod = is_div || is_mod;

`ifdef LC4_ALU_DIV_ZERO_FAST_EN
  assign fast_zero = is_divmod && (i_r2data == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign o_ready   = (state == ST_IDLE) || ((state == ST_DONE) && i_ready);
  assign accept    = i_valid && o_ready;
  assign div_start = accept && is_divmod && !fast_zero;

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_BR: alu_res = pc_inc + imm9_s;
      OP_ARITH: begin
        if (i_insn[5]) alu_res = i_r1data + imm5_s;
        else begin
          case (i_insn[5:3])
            AR_ADD:  alu_res = i_r1data + i_r2data;
            AR_MUL:  alu_res = i_r1data * i_r2data;
            AR_SUB:  alu_res = i_r1data - i_r2data;
            default: alu_res = '0;
          endcase
        end
      end
      OP_CMP: begin
        case (i_insn[8:7])
          CMP_S:   alu_res = cmp3(i_r1data, i_r2data, 1'b1);
          CMP_U:   alu_res = cmp3(i_r1data, i_r2data, 1'b0);
          CMP_SI:  alu_res = cmp3(i_r1data, imm7_s, 1'b1);
          default: alu_res = cmp3(i_r1data, imm7_u, 1'b0);
        endcase
      end
      OP_JSR: alu_res = i_insn[11] ? ((i_pc & MSB) | (imm11_s << 4)) : i_r1data;
      OP_LOGIC: begin
        if (i_insn[5]) alu_res = i_r1data & imm5_s;
        else begin
          case (i_insn[5:3])
            LG_AND:  alu_res = i_r1data & i_r2data;
            LG_NOT:  alu_res = ~i_r1data;
            LG_OR:   alu_res = i_r1data | i_r2data;
            default: alu_res = i_r1data ^ i_r2data;
          endcase
        end
      end
      OP_LDR, OP_STR: alu_res = i_r1data + imm6_s;
      OP_RTI:         alu_res = i_r1data;
      OP_CONST:       alu_res = imm9_s;
      OP_SHIFT: begin
        case (i_insn[5:4])
          SH_SLL:  alu_res = i_r1data << shamt;
          SH_SRA:  alu_res = r1_s >>> shamt;
          SH_SRL:  alu_res = i_r1data >> shamt;
          default: alu_res = '0;
        endcase
      end
      OP_JMP:     alu_res = i_insn[11] ? (pc_inc + imm11_s) : i_r1data;
      // Only bits 15:8 are replaced so wider datapaths keep r1 above bit 15.
      OP_HICONST: alu_res = (i_r1data & ~WIDTH'(16'hFF00)) | (WIDTH'(i_insn[7:0]) << 8);
      OP_TRAP:    alu_res = MSB | WIDTH'(i_insn[7:0]);
      default:    alu_res = '0;
    endcase
  end

  lc4_div_iter #(
    .WIDTH    (WIDTH),
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (i_r1data),
    .divisor   (i_r2data),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Result register stage: written at accept for ALU ops, at divider completion for DIV/MOD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      o_valid    <= 1'b0;
      o_result   <= '0;
      mod_sel_p0 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            mod_sel_p0 <= is_mod;
            if (div_start) begin
              state   <= ST_DIV;
              o_valid <= 1'b0;
            end else begin
              state    <= ST_DONE;
              o_valid  <= 1'b1;
              o_result <= alu_res;
            end
          end else if (state == ST_DONE && i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
          end
        end
        ST_DIV: begin
          // A divider that is somehow idle must not strand the FSM here.
          if (div_done || !div_busy) begin
            state    <= ST_DONE;
            o_valid  <= 1'b1;
            o_result <= mod_sel_p0 ? div_rem : div_quo;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_alu_seq.sv
// Scoreboard bench for lc4_alu_seq: directed latency/backpressure/reset cases,
// then randomized instructions checked against a behavioural LC4 model.
module tb_lc4_alu_seq;

  localparam int WIDTH    = 16;
  localparam int DIV_BITS = 1;
  localparam int N_DIV    = WIDTH / DIV_BITS;
`ifdef LC4_ALU_DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 0;
`else
  localparam int DZ_LAT = N_DIV + 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b0;
  logic             o_ready, o_valid;
  logic [15:0]      i_insn = '0;
  logic [WIDTH-1:0] i_pc = '0, i_r1data = '0, i_r2data = '0;
  logic [WIDTH-1:0] o_result;

  int               n_checks = 0;
  int               n_pass = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  lc4_alu_seq #(.WIDTH(WIDTH), .DIV_BITS(DIV_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_insn   (i_insn),
    .i_pc     (i_pc),
    .i_r1data (i_r1data),
    .i_r2data (i_r2data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  function automatic longint sx(input longint v, input int bits);
    longint m;
    m = v & ((longint'(1) << bits) - 1);
    if (m >= (longint'(1) << (bits - 1))) m = m - (longint'(1) << bits);
    return m;
  endfunction

  function automatic longint cmpv(input longint a, input longint b);
    return (a > b) ? 1 : ((a == b) ? 0 : -1);
  endfunction

  // Reference semantics of the LC4 execute stage at 16 bits.
  function automatic logic [15:0] model(input logic [15:0] insn, input logic [15:0] pc,
                                        input logic [15:0] r1, input logic [15:0] r2);
    longint u1, u2, s1, p, res;
    int amt;
    u1 = longint'(r1); u2 = longint'(r2); s1 = sx(u1, 16); p = longint'(pc);
    amt = int'(insn[3:0]);
    res = 0;
    case (insn[15:12])
      4'h0: res = p + 1 + sx(longint'(insn), 9);
      4'h1: case (insn[5:3])
              3'd0: res = u1 + u2;
              3'd1: res = u1 * u2;
              3'd2: res = u1 - u2;
              3'd3: res = (u2 == 0) ? 0 : u1 / u2;
              default: res = u1 + sx(longint'(insn), 5);
            endcase
      4'h2: case (insn[8:7])
              2'd0: res = cmpv(s1, sx(u2, 16));
              2'd1: res = cmpv(u1, u2);
              2'd2: res = cmpv(s1, sx(longint'(insn), 7));
              default: res = cmpv(u1, longint'(insn[6:0]));
            endcase
      4'h4: res = insn[11] ? ((p & 'h8000) | (sx(longint'(insn), 11) * 16)) : u1;
      4'h5: case (insn[5:3])
              3'd0: res = u1 & u2;
              3'd1: res = ~u1;
              3'd2: res = u1 | u2;
              3'd3: res = u1 ^ u2;
              default: res = u1 & sx(longint'(insn), 5);
            endcase
      4'h6, 4'h7: res = u1 + sx(longint'(insn), 6);
      4'h8: res = u1;
      4'h9: res = sx(longint'(insn), 9);
      4'hA: case (insn[5:4])
              2'd0: res = u1 << amt;
              2'd1: res = s1 >>> amt;
              2'd2: res = u1 >> amt;
              default: res = (u2 == 0) ? 0 : u1 % u2;
            endcase
      4'hC: res = insn[11] ? (p + 1 + sx(longint'(insn), 11)) : u1;
      4'hD: res = (u1 & 'hFF) | (longint'(insn[7:0]) * 256);
      4'hF: res = 'h8000 | longint'(insn[7:0]);
      default: res = 0;
    endcase
    return res[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every result the consumer takes is compared against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL result: got 0x%0h with no request outstanding, expected none", o_result);
        end else begin
          check("result", 64'(o_result), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [15:0] insn, input logic [WIDTH-1:0] pc,
                      input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2,
                      input logic rdy, output int waited);
    @(negedge clk);
    i_insn = insn; i_pc = pc; i_r1data = r1; i_r2data = r2;
    i_ready = rdy; i_valid = 1'b1;
    #1;
    waited = 0;
    while (!o_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!o_ready) begin
      n_checks++;
      $display("FAIL accept: o_ready 0 after %0d cycles, expected 1", waited);
    end else begin
      exp_q.push_back(model(insn, pc, r1, r2));
    end
    @(posedge clk);
  endtask

  task automatic wait_valid(output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    #1;
    i_valid = 1'b0;
    while (!o_valid && lat < 60) begin
      if (o_ready) rdy_seen = 1'b1;
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  initial begin
    int lat, w;
    bit rs;
    int issued, pend_cyc, g;
    bit pending;
    logic [15:0] rin;

    #2;
    check("rst_valid", 64'(o_valid), 64'h0);
    check("rst_result", 64'(o_result), 64'h0);
    check("rst_ready", 64'(o_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    send(16'h1000, 16'h0040, 16'h0005, 16'hFFFD, 1'b1, w);
    wait_valid(lat, rs);
    check("add_latency", 64'(lat), 64'h0);
    check("add_value", 64'(o_result), 64'h0002);

    send(16'h1018, 16'h0000, 16'd100, 16'd7, 1'b1, w);
    wait_valid(lat, rs);
    check("div_latency", 64'(lat), 64'(N_DIV + 1));
    check("div_ready_low", 64'(rs), 64'h0);
    check("div_value", 64'(o_result), 64'h000E);

    send(16'hA030, 16'h0000, 16'd100, 16'd7, 1'b1, w);
    wait_valid(lat, rs);
    check("mod_latency", 64'(lat), 64'(N_DIV + 1));
    check("mod_value", 64'(o_result), 64'h0002);

    send(16'h1018, 16'h0000, 16'd1234, 16'd0, 1'b1, w);
    wait_valid(lat, rs);
    check("divzero_latency", 64'(lat), 64'(DZ_LAT));
    check("divzero_value", 64'(o_result), 64'h0000);

    send(16'h2000, 16'h0000, 16'hFFFF, 16'h0001, 1'b1, w);
    #1;
    check("cmp_value", 64'(o_result), 64'hFFFF);
    send(16'h2080, 16'h0000, 16'hFFFF, 16'h0001, 1'b1, w);
    check("cmpu_b2b_wait", 64'(w), 64'h0);
    #1;
    check("cmpu_value", 64'(o_result), 64'h0001);
    wait_valid(lat, rs);

    // Let the CMPU result drain before stalling the consumer.
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk);

    send(16'h1000, 16'h0000, 16'd3, 16'd4, 1'b0, w);
    #1;
    i_valid = 1'b0;
    check("bp_value", 64'(o_result), 64'h0007);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("bp_stable", 64'(o_result), 64'h0007);
      check("bp_valid", 64'(o_valid), 64'h1);
      check("bp_ready", 64'(o_ready), 64'h0);
    end
    send(16'h1010, 16'h0000, 16'd10, 16'd4, 1'b1, w);
    check("bp_accept_wait", 64'(w), 64'h0);
    wait_valid(lat, rs);
    check("bp_next_value", 64'(o_result), 64'h0006);

    send(16'h1018, 16'h0000, 16'd100, 16'd7, 1'b1, w);
    #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", 64'(o_valid), 64'h0);
    check("abort_result", 64'(o_result), 64'h0);
    check("abort_ready", 64'(o_ready), 64'h1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send(16'h1000, 16'h0000, 16'h1234, 16'h0101, 1'b1, w);
    wait_valid(lat, rs);
    check("post_abort_latency", 64'(lat), 64'h0);
    check("post_abort_value", 64'(o_result), 64'h1335);

    issued = 0; pend_cyc = 0; pending = 1'b0;
    for (int cyc = 0; cyc < 8000 && (issued < 300 || pending); cyc++) begin
      @(negedge clk);
      i_ready = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        i_valid = 1'b0;
        if (issued < 300 && $urandom_range(0, 4) != 0) begin
          rin = 16'($urandom);
          case ($urandom_range(0, 7))
            0: rin = {4'h1, rin[11:6], 3'b011, rin[2:0]};
            1: rin = {4'hA, rin[11:6], 2'b11, rin[3:0]};
            default: ;
          endcase
          i_insn = rin;
          i_pc = 16'($urandom);
          i_r1data = 16'($urandom);
          case ($urandom_range(0, 3))
            0: i_r2data = '0;
            1: i_r2data = 16'($urandom_range(1, 15));
            default: i_r2data = 16'($urandom);
          endcase
          i_valid = 1'b1;
          pending = 1'b1;
          pend_cyc = 0;
          issued++;
        end
      end
      #1;
      if (pending && o_ready) begin
        exp_q.push_back(model(i_insn, i_pc, i_r1data, i_r2data));
        pending = 1'b0;
      end else if (pending) begin
        pend_cyc++;
        if (pend_cyc > 60) begin
          n_checks++;
          $display("FAIL rand_accept: o_ready 0 for %0d cycles, expected 1", pend_cyc);
          break;
        end
      end
    end

    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    g = 0;
    while ((exp_q.size() != 0 || o_valid) && g < 100) begin
      @(negedge clk);
      g++;
    end
    #3;
    check("drain", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
